// File: rtl/square_lut_rr_arbiter.sv
// Round-robin arbiter sharing one signed 4-bit square LUT among NumReq requesters.
// The result is held in a single response slot tagged with the requester ID.
module square_lut_rr_arbiter #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdW = $clog2(NumReq)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumReq-1:0]     req_valid_i,
  input  logic [4*NumReq-1:0]   req_data_i,
  output logic [NumReq-1:0]     req_ready_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [7:0]            rsp_data_o,
  output logic [IdW-1:0]        rsp_id_o
);

  logic [IdW-1:0] ptr_q, ptr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [7:0]     rsp_data_q, rsp_data_d;
  logic [IdW-1:0] rsp_id_q, rsp_id_d;

  logic           slot_free;
  logic           gnt_found;
  logic [IdW-1:0] gnt_idx;
  logic [IdW:0]   idx_ext;
  logic [3:0]     operand;
  logic [7:0]     lut_out;

  assign slot_free = !rsp_valid_q || rsp_ready_i;

  // Circular search starting at the pointer; the extra bit absorbs the wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx_ext   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx_ext = {1'b0, ptr_q} + (IdW+1)'(k);
      if (idx_ext >= (IdW+1)'(NumReq)) begin
        idx_ext = idx_ext - (IdW+1)'(NumReq);
      end
      if (!gnt_found && req_valid_i[idx_ext[IdW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_ext[IdW-1:0];
      end
    end
  end

  // Reset gates the grant so no requester sees ready while held in reset.
  always_comb begin
    req_ready_o = '0;
    if (rst_ni && slot_free && gnt_found) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  assign operand = req_data_i[{gnt_idx, 2'b00} +: 4];

  always_comb begin
    lut_out = 8'd0;
    unique case (operand)
      4'h0: lut_out = 8'd0;
      4'h1: lut_out = 8'd1;
      4'h2: lut_out = 8'd4;
      4'h3: lut_out = 8'd9;
      4'h4: lut_out = 8'd16;
      4'h5: lut_out = 8'd25;
      4'h6: lut_out = 8'd36;
      4'h7: lut_out = 8'd49;
      4'h8: lut_out = 8'd64;
      4'h9: lut_out = 8'd49;
      4'ha: lut_out = 8'd36;
      4'hb: lut_out = 8'd25;
      4'hc: lut_out = 8'd16;
      4'hd: lut_out = 8'd9;
      4'he: lut_out = 8'd4;
      4'hf: lut_out = 8'd1;
      default: lut_out = 8'd0;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    if (slot_free && gnt_found) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = lut_out;
      rsp_id_d    = gnt_idx;
      ptr_d       = (gnt_idx == IdW'(NumReq - 1)) ? '0 : gnt_idx + IdW'(1);
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;

endmodule

// File: tb/tb_square_lut_rr_arbiter.sv
// Self-checking bench for square_lut_rr_arbiter: directed scenarios plus random traffic
// compared against a transaction-level model of the arbiter and response slot.
module tb_square_lut_rr_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [7:0]     rsp_data;
  logic [1:0]     rsp_id;

  int checks   = 0;
  int failures = 0;

  // Model state: response slot contents and next-priority requester.
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_id;
  int         m_ptr;

  square_lut_rr_arbiter #(.NumReq(N)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .rsp_id_o   (rsp_id)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sq(input logic [3:0] n);
    int v;
    v = $signed(n);
    return 8'(v * v);
  endfunction

  function automatic int exp_grant();
    if (!rst_n) return -1;
    if (m_valid && !rsp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(input int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'd0;
    m_id    = 2'd0;
    m_ptr   = 0;
  endtask

  task automatic model_tick(input int g);
    if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = sq(req_data[4*g +: 4]);
      m_id    = 2'(g);
      m_ptr   = (g + 1) % N;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic set_data(input int i, input int v);
    req_data[4*i +: 4] = 4'(v);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = '0;
    rsp_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== 11'd0) begin
      failures++; $display("FAIL reset_outputs got valid=%b id=%0d data=%0d exp 0/0/0",
                           rsp_valid, rsp_id, rsp_data);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_sweep();
    int g;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      req_valid = (c < 16) ? 4'b0100 : 4'b0000;
      set_data(2, c - 8);
      rsp_ready = 1'b1;
      #1;
      g = exp_grant();
      checks++;
      if (req_ready !== exp_ready(g)) begin
        failures++; $display("FAIL sweep_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready(g));
      end
      checks++;
      if (rsp_valid !== m_valid || {rsp_id, rsp_data} !== {m_id, m_data}) begin
        failures++; $display("FAIL sweep_rsp c=%0d got v=%b id=%0d d=%0d exp v=%b id=%0d d=%0d",
                             c, rsp_valid, rsp_id, rsp_data, m_valid, m_id, m_data);
      end
      model_tick(g);
    end
  endtask

  task automatic test_round_robin();
    int g;
    set_data(0, -8); set_data(1, -3); set_data(2, 0); set_data(3, 7);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req_valid = '1;
      rsp_ready = 1'b1;
      #1;
      g = exp_grant();
      checks++;
      if (req_ready !== exp_ready(g)) begin
        failures++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready(g));
      end
      checks++;
      if (rsp_valid !== m_valid || {rsp_id, rsp_data} !== {m_id, m_data}) begin
        failures++; $display("FAIL rr_rsp c=%0d got v=%b id=%0d d=%0d exp v=%b id=%0d d=%0d",
                             c, rsp_valid, rsp_id, rsp_data, m_valid, m_id, m_data);
      end
      model_tick(g);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    model_tick(exp_grant());
  endtask

  task automatic test_backpressure();
    int g;
    // Load id 1 / data 9 alone so the pointer lands on 2.
    @(negedge clk);
    req_valid = 4'b0010; set_data(1, -3); rsp_ready = 1'b1;
    #1;
    model_tick(exp_grant());
    @(negedge clk);
    req_valid = 4'b1001; set_data(0, 5); set_data(3, 7); rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_data !== 8'd9 || rsp_id !== 2'd1)
      begin
        failures++; $display("FAIL bp_hold c=%0d got rdy=%b v=%b id=%0d d=%0d exp 0000/1/1/9",
                             c, req_ready, rsp_valid, rsp_id, rsp_data);
      end
      model_tick(exp_grant());
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    g = exp_grant();
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++; $display("FAIL bp_release_ready got=%b exp=1000", req_ready);
    end
    model_tick(g);
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 8'd49) begin
      failures++; $display("FAIL bp_release_rsp got v=%b id=%0d d=%0d exp 1/3/49",
                           rsp_valid, rsp_id, rsp_data);
    end
    model_tick(exp_grant());
  endtask

  task automatic test_wrap();
    // Pointer is 0 after the backpressure test's grant to 3; grant 2 to move it to 3.
    @(negedge clk);
    req_valid = 4'b0100; set_data(2, 1); rsp_ready = 1'b1;
    #1;
    model_tick(exp_grant());
    @(negedge clk);
    req_valid = 4'b0010; set_data(1, -1);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL wrap_ready got=%b exp=0010", req_ready);
    end
    model_tick(exp_grant());
    @(negedge clk);
    req_valid = '1;
    #1;
    checks++;
    if (rsp_data !== 8'd1 || rsp_id !== 2'd1) begin
      failures++; $display("FAIL wrap_rsp got id=%0d d=%0d exp 1/1", rsp_id, rsp_data);
    end
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++; $display("FAIL wrap_next_ready got=%b exp=0100", req_ready);
    end
    model_tick(exp_grant());
  endtask

  task automatic test_idle_drain();
    @(negedge clk);
    req_valid = '0; rsp_ready = 1'b1;
    #1;
    model_tick(exp_grant());
    @(negedge clk);
    req_valid = 4'b0001; set_data(0, 6);
    #1;
    model_tick(exp_grant());
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++;
      if (rsp_valid !== (c == 0) || req_ready !== 4'b0000 || rsp_data !== 8'd36) begin
        failures++; $display("FAIL idle_drain c=%0d got v=%b rdy=%b d=%0d exp v=%b rdy=0000 d=36",
                             c, rsp_valid, req_ready, rsp_data, (c == 0));
      end
      model_tick(exp_grant());
    end
  endtask

  task automatic test_random();
    int g;
    g = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (g >= 0) req_valid[g] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 2) != 0)) begin
          req_valid[i] = 1'b1;
          set_data(i, int'($urandom_range(0, 15)));
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      #1;
      g = exp_grant();
      checks++;
      if (req_ready !== exp_ready(g)) begin
        failures++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready(g));
      end
      checks++;
      if (rsp_valid !== m_valid || {rsp_id, rsp_data} !== {m_id, m_data}) begin
        failures++; $display("FAIL rand_rsp c=%0d got v=%b id=%0d d=%0d exp v=%b id=%0d d=%0d",
                             c, rsp_valid, rsp_id, rsp_data, m_valid, m_id, m_data);
      end
      model_tick(g);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req_valid = '1; rsp_ready = 1'b1;
    set_data(0, 3); set_data(1, -2); set_data(2, 4); set_data(3, -5);
    #1;
    model_tick(exp_grant());
    @(negedge clk);
    #3;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++; $display("FAIL arst_pre_valid got=%b exp=1", rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'd0 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
      failures++; $display("FAIL arst_now got v=%b id=%0d d=%0d rdy=%b exp 0/0/0/0000",
                           rsp_valid, rsp_id, rsp_data, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL arst_first_grant got=%b exp=0001", req_ready);
    end
    model_tick(exp_grant());
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'd9) begin
      failures++; $display("FAIL arst_first_rsp got v=%b id=%0d d=%0d exp 1/0/9",
                           rsp_valid, rsp_id, rsp_data);
    end
    model_tick(exp_grant());
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_idle_drain();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
